// File: rtl/pixel_line_streamer_pkg.sv
// Shared types and constants for pixel_line_streamer.
// The StPad state exists only when PIXEL_LINE_STREAMER_PAD_EN is defined.
package pixel_line_streamer_pkg;

  localparam int unsigned PLS_CREDIT_W   = 2;
  localparam int unsigned PLS_FIFO_DEPTH = 2;
  localparam int unsigned PLS_COUNT_W    = $clog2(PLS_FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StWait,
    StLine,
`ifdef PIXEL_LINE_STREAMER_PAD_EN
    StPad,
`endif
    StDrain
  } pls_state_t;

endpackage

// File: rtl/pls_skid_fifo.sv
// Two-entry synchronous FIFO with registered head, flags and count.
// Entry 0 is always the head, so data_o only moves on a pop or a push into an empty FIFO.
module pls_skid_fifo
  import pixel_line_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [PLS_COUNT_W-1:0] count_o
);

  logic [DATA_W-1:0]      data_q [PLS_FIFO_DEPTH];
  logic [DATA_W-1:0]      data_d [PLS_FIFO_DEPTH];
  logic [PLS_COUNT_W-1:0] count_q, count_d;
  logic                   empty_q, full_q;
  logic                   do_push, do_pop;

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    do_pop  = pop_i && !empty_q;
    do_push = push_i && (!full_q || do_pop);
    if (do_pop) begin
      data_d[0] = data_q[1];
    end
    if (do_push) begin
      if (empty_q || (count_q == PLS_COUNT_W'(1) && do_pop)) begin
        data_d[0] = data_i;
      end else begin
        data_d[1] = data_i;
      end
    end
    if (do_push && !do_pop) begin
      count_d = count_q + PLS_COUNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - PLS_COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '{default: '0};
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == PLS_COUNT_W'(PLS_FIFO_DEPTH));
    end
  end

  assign data_o  = data_q[0];
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/pixel_line_streamer.sv
// Line-paced pixel source: primes the consumer, then sends one line per interrupt credit.
// Define PIXEL_LINE_STREAMER_PAD_EN to append PAD_LINES credit-gated zero lines per frame.
module pixel_line_streamer
  import pixel_line_streamer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 512,
  parameter int unsigned IMG_HEIGHT  = 512,
  parameter int unsigned PRIME_LINES = 4,
  parameter int unsigned PAD_LINES   = 2,
  parameter int unsigned DATA_W      = 8,
  localparam int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_data_ready,
  input  logic              i_intr
);

  localparam int unsigned PIX_W      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned LINE_W     = $clog2(IMG_HEIGHT + PAD_LINES + 1);
  localparam int unsigned PRIME_STOP = (PRIME_LINES < IMG_HEIGHT) ? PRIME_LINES : IMG_HEIGHT;

  pls_state_t              state_q, state_d;
  logic [PIX_W-1:0]        pix_q, pix_d;
  logic [LINE_W-1:0]       line_q, line_d, line_inc;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [PLS_CREDIT_W-1:0] credit_q, credit_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    intr_q, inflight_q, zero_q;
  logic                    issue, issue_zero, take_credit, intr_rise, pop, can_issue;
  logic                    fifo_empty, fifo_full;
  logic [PLS_COUNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0]       fifo_wdata, fifo_rdata;

  assign pop       = !fifo_empty && i_data_ready;
  assign intr_rise = i_intr && !intr_q;
  assign line_inc  = line_q + LINE_W'(1);
  // Occupancy after this cycle's pop plus the beat landing from memory must stay below 2.
  assign can_issue = fifo_empty || (!fifo_full && (!inflight_q || pop)) ||
                     (fifo_full && pop && !inflight_q);

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    addr_d      = addr_q;
    credit_d    = credit_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    issue_zero  = 1'b0;
    take_credit = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StPrime;
          busy_d  = 1'b1;
        end
      end
      StPrime, StLine: issue = can_issue;
`ifdef PIXEL_LINE_STREAMER_PAD_EN
      StPad: begin
        issue      = can_issue;
        issue_zero = 1'b1;
      end
`endif
      StWait: begin
        if (line_q < LINE_W'(IMG_HEIGHT)) begin
          if (credit_q != '0) begin
            state_d     = StLine;
            take_credit = 1'b1;
          end
        end else begin
`ifdef PIXEL_LINE_STREAMER_PAD_EN
          if (credit_q != '0) begin
            state_d     = StPad;
            take_credit = 1'b1;
          end
`else
          state_d = StDrain;
`endif
        end
      end
      StDrain: begin
        if (!inflight_q && fifo_count == PLS_COUNT_W'(1) && pop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          line_d  = '0;
          addr_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      if (!issue_zero) begin
        addr_d = addr_q + ADDR_W'(1);
      end
      if (pix_q == PIX_W'(IMG_WIDTH - 1)) begin
        pix_d   = '0;
        line_d  = line_inc;
        state_d = StWait;
        if (state_q == StPrime && line_inc != LINE_W'(PRIME_STOP)) begin
          state_d = StPrime;
        end
`ifdef PIXEL_LINE_STREAMER_PAD_EN
        if (state_q == StPad && line_inc == LINE_W'(IMG_HEIGHT + PAD_LINES)) begin
          state_d = StDrain;
        end
`endif
      end else begin
        pix_d = pix_q + PIX_W'(1);
      end
    end

    if (state_q == StIdle) begin
      credit_d = '0;
    end else if (intr_rise && !take_credit) begin
      if (credit_q != '1) begin
        credit_d = credit_q + PLS_CREDIT_W'(1);
      end
    end else if (!intr_rise && take_credit) begin
      credit_d = credit_q - PLS_CREDIT_W'(1);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q    <= StIdle;
      pix_q      <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      credit_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      intr_q     <= 1'b0;
      inflight_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
      credit_q   <= credit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      intr_q     <= i_intr;
      inflight_q <= issue;
      zero_q     <= issue_zero;
    end
  end

  assign fifo_wdata = zero_q ? '0 : i_rd_data;

  pls_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (axi_clk),
    .rst_i   (axi_reset),
    .push_i  (inflight_q),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_rd_en      = issue && !issue_zero;
  assign o_rd_addr    = addr_q;
  assign o_data_valid = !fifo_empty;
  assign o_data       = fifo_rdata;

endmodule

// File: tb/tb_pixel_line_streamer.sv
// Directed bench for pixel_line_streamer on an 8x6 frame; expectations follow
// PIXEL_LINE_STREAMER_PAD_EN so the same bench covers both builds.
module tb_pixel_line_streamer;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 6;
  localparam int unsigned NPIX = W * H;
`ifdef PIXEL_LINE_STREAMER_PAD_EN
  localparam bit          PAD_ON = 1'b1;
  localparam int unsigned NBEATS = (H + 2) * W;
`else
  localparam bit          PAD_ON = 1'b0;
  localparam int unsigned NBEATS = H * W;
`endif

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1, intr = 1'b0;
  logic [7:0] rd_data = '0;
  logic       busy, done, rd_en, valid;
  logic [5:0] rd_addr;
  logic [7:0] data;

  int checks = 0, failures = 0;
  int unsigned beats[$];
  int unsigned reads[$];
  int cyc = 0, hs_cyc = 0, done_cyc = 0, done_cnt = 0, stall_err = 0, ovf_err = 0;
  bit done_busy, done_prev_busy, prev_busy, prev_stall;
  logic [7:0] prev_data;

  pixel_line_streamer #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .PRIME_LINES (4),
    .PAD_LINES   (2),
    .DATA_W      (8)
  ) u_dut (
    .axi_clk      (clk),
    .axi_reset    (rst),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_data_valid (valid),
    .o_data       (data),
    .i_data_ready (ready),
    .i_intr       (intr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Synchronous-read memory holding address mod 256.
  always @(posedge clk) if (rd_en) rd_data <= {2'b00, rd_addr};

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (prev_stall && (!valid || data !== prev_data)) stall_err++;
      prev_stall = valid && !ready;
      prev_data  = data;
      if (valid && ready) begin
        beats.push_back(int'(data));
        hs_cyc = cyc;
      end
      if (rd_en) reads.push_back(int'(rd_addr));
      if (done) begin
        done_cnt++;
        done_cyc       = cyc;
        done_busy      = busy;
        done_prev_busy = prev_busy;
      end
      if (u_dut.u_fifo.count_o > 2'd2) ovf_err++;
      prev_busy = busy;
    end
  end

  function automatic int unsigned exp_beat(input int unsigned i);
    return (i < NPIX) ? i : 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_intr();
    intr = 1'b1;
    tick(2);
    intr = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound);
    int n = 0;
    while (done_cnt == base && n < bound) begin
      tick(1);
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      failures++;
      $display("FAIL done_timeout got=no_done exp=done_within_%0d", bound);
    end
  endtask

  task automatic check_frame(input string tag);
    int lim = (beats.size() < NBEATS) ? beats.size() : NBEATS;
    int aerr = 0;
    checks++;
    if (beats.size() != NBEATS) begin
      failures++;
      $display("FAIL %s_beat_count got=%0d exp=%0d", tag, beats.size(), NBEATS);
    end
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (beats[i] !== exp_beat(i)) begin
        failures++;
        $display("FAIL %s_beat%0d got=%0d exp=%0d", tag, i, beats[i], exp_beat(i));
      end
    end
    for (int i = 0; i < reads.size(); i++) if (reads[i] != i) aerr++;
    checks++;
    if (reads.size() != NPIX || aerr != 0) begin
      failures++;
      $display("FAIL %s_reads got=%0d/%0d_bad exp=%0d/0_bad", tag, reads.size(), aerr, NPIX);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (rd_addr !== 6'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rd_addr); end
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", data); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_prime();
    int aerr = 0;
    beats.delete(); reads.delete();
    ready = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
    checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL start_rd_en got=%b exp=1", rd_en); end
    checks++; if (rd_addr !== 6'd0) begin failures++; $display("FAIL start_addr got=%0d exp=0", rd_addr); end
    tick(1);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL cycle2_valid got=%b exp=0", valid); end
    tick(1);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL cycle3_valid got=%b exp=1", valid); end
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL cycle3_data got=%0d exp=0", data); end
    tick(60);
    checks++;
    if (beats.size() != 32) begin
      failures++;
      $display("FAIL prime_beats got=%0d exp=32", beats.size());
    end
    for (int i = 0; i < beats.size() && i < 32; i++) if (beats[i] != i) aerr++;
    for (int i = 0; i < reads.size(); i++) if (reads[i] != i) aerr++;
    checks++;
    if (reads.size() != 32 || aerr != 0) begin
      failures++;
      $display("FAIL prime_reads got=%0d/%0d_bad exp=32/0_bad", reads.size(), aerr);
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prime_wait_busy got=%b exp=1", busy); end
  endtask

  task automatic test_credit_frame();
    int base = done_cnt;
    intr = 1'b1;
    tick(1);
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL credit_k_rd_en got=%b exp=0", rd_en); end
    tick(1);
    checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL credit_k1_rd_en got=%b exp=1", rd_en); end
    checks++; if (rd_addr !== 6'd32) begin failures++; $display("FAIL credit_addr got=%0d exp=32", rd_addr); end
    tick(1);
    intr = 1'b0;
    for (int p = 0; p < 3; p++) begin
      tick(17);
      pulse_intr();
    end
    wait_done(base, 300);
    tick(5);
    check_frame("frame");
    checks++;
    if (done_cnt != base + 1) begin
      failures++;
      $display("FAIL done_pulses got=%0d exp=1", done_cnt - base);
    end
    checks++;
    if (done_cyc != hs_cyc + 1) begin
      failures++;
      $display("FAIL done_latency got=%0d exp=%0d", done_cyc, hs_cyc + 1);
    end
    checks++;
    if (done_busy !== 1'b0 || done_prev_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_at_done got=%b/%b exp=0/1", done_busy, done_prev_busy);
    end
  endtask

  task automatic test_backpressure();
    int base = done_cnt;
    int n = 0;
    beats.delete(); reads.delete();
    stall_err = 0; ovf_err = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    while (done_cnt == base && n < 3000) begin
      ready = 1'($urandom_range(0, 1));
      intr  = ((n % 40) < 2);
      tick(1);
      n++;
    end
    ready = 1'b1;
    intr  = 1'b0;
    checks++;
    if (done_cnt == base) begin
      failures++;
      $display("FAIL bp_timeout got=no_done exp=done");
    end
    tick(3);
    check_frame("bp");
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stall got=%0d exp=0", stall_err); end
    checks++; if (ovf_err != 0) begin failures++; $display("FAIL bp_overflow got=%0d exp=0", ovf_err); end
  endtask

  task automatic test_prime_credits();
    int base = done_cnt;
    beats.delete(); reads.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    pulse_intr();
    tick(8);
    pulse_intr();
    tick(100);
    checks++;
    if (reads.size() != NPIX) begin
      failures++;
      $display("FAIL pc_reads got=%0d exp=%0d", reads.size(), NPIX);
    end
    checks++;
    if (beats.size() != NPIX) begin
      failures++;
      $display("FAIL pc_beats got=%0d exp=%0d", beats.size(), NPIX);
    end
    checks++;
    if (done_cnt != base + (PAD_ON ? 0 : 1)) begin
      failures++;
      $display("FAIL pc_done got=%0d exp=%0d", done_cnt - base, PAD_ON ? 0 : 1);
    end
    if (PAD_ON) begin
      pulse_intr();
      tick(20);
      checks++;
      if (beats.size() != NPIX + W) begin
        failures++;
        $display("FAIL pc_pad_line got=%0d exp=%0d", beats.size(), NPIX + W);
      end
      pulse_intr();
      wait_done(base, 100);
    end
    tick(3);
    check_frame("pc");
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    beats.delete(); reads.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    while (beats.size() < 20 && n < 100) begin
      tick(1);
      n++;
    end
    rst = 1'b1;
    tick(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL mid_rd_en got=%b exp=0", rd_en); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", valid); end
    checks++; if (rd_addr !== 6'd0) begin failures++; $display("FAIL mid_addr got=%0d exp=0", rd_addr); end
    checks++; if (data !== 8'd0) begin failures++; $display("FAIL mid_data got=%0d exp=0", data); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", done); end
    rst = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 6'd0) begin
      failures++;
      $display("FAIL restart_read got=%b@%0d exp=1@0", rd_en, rd_addr);
    end
    tick(2);
    checks++;
    if (valid !== 1'b1 || data !== 8'd0) begin
      failures++;
      $display("FAIL restart_beat got=%b/%0d exp=1/0", valid, data);
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_prime();
    test_credit_frame();
    test_backpressure();
    test_prime_credits();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_line_streamer.md
# pixel_line_streamer

Line-paced pixel source that drives the slave-side stream input of `imageprocessingtop`. It reads an 8-bit grayscale frame from a synchronous-read pixel memory and sends the first PRIME_LINES lines back to back. After that it sends one line per interrupt pulse from the processing core, then flushes the core's line buffers with PAD_LINES all-zero lines. It is the hardware counterpart of the receiver's line-credit protocol and replaces software-driven pixel feeding.

## Interface
- `IMG_WIDTH`, 512, pixels per line
- `IMG_HEIGHT`, 512, lines per frame
- `PRIME_LINES`, 4, lines sent before the first interrupt is required
- `PAD_LINES`, 2, zero lines appended after the frame
- `DATA_W`, 8, pixel width
- `axi_clk`  in  1  sole clock, rising edge
- `axi_reset`  in  1  synchronous, active-high reset
- `i_start`  in  1  one-cycle start pulse; ignored while `o_busy`
- `o_busy`  out  1  high from the cycle after start is accepted until `o_done`
- `o_done`  out  1  one-cycle pulse when the last pixel is accepted
- `o_rd_en`  out  1  pixel memory read strobe
- `o_rd_addr`  out  $clog2(IMG_WIDTH*IMG_HEIGHT)  linear pixel address, raster order
- `i_rd_data`  in  DATA_W  read data, valid exactly 1 cycle after `o_rd_en`
- `o_data_valid`  out  1  stream valid to the processing core
- `o_data`  out  DATA_W  stream pixel
- `i_data_ready`  in  1  stream ready from the processing core
- `i_intr`  in  1  line-consumed interrupt from the processing core, level signal, rising edge counted

## Operation
- Reset values: `o_busy`, `o_done`, `o_rd_en`, and `o_data_valid` are 0. `o_rd_addr` and `o_data` are 0. The FSM is in IDLE, the credit counter is 0 and the FIFO is empty.
- FSM states:
  - IDLE: on `i_start`, go to PRIME.
  - PRIME: after PRIME_LINES lines are issued, go to WAIT.
  - WAIT: when credit > 0, go to LINE, or to PAD if all image lines have been issued.
  - LINE: after one line is issued, go to WAIT.
  - PAD: after one zero line is issued, go to WAIT; once PAD_LINES zero lines are issued, go to DRAIN.
  - DRAIN: when the FIFO is empty and the last beat is accepted, pulse `o_done` and go to IDLE.
- Issue rule: a read (or a zero write in PAD) is issued only when FIFO occupancy plus in-flight reads is less than 2. A 2-entry FIFO absorbs the 1-cycle memory latency under backpressure.
- A stream beat transfers when `o_data_valid` and `i_data_ready` are both high. `o_data` and `o_data_valid` are held stable while ready is low.
- Credits:
  - A 2-bit saturating counter, incremented on each `i_intr` rising edge (registered edge detect).
  - Decremented when WAIT leaves toward LINE or PAD.
  - Simultaneous increment and decrement leaves it unchanged.
  - Edges are counted in every non-IDLE state, including PRIME and LINE. The counter is cleared in IDLE.
- Counts: exactly (IMG_HEIGHT+PAD_LINES)*IMG_WIDTH beats per frame; exactly IMG_HEIGHT*IMG_WIDTH reads, with addresses 0..N-1 ascending and each issued once.
- If PRIME_LINES ≥ IMG_HEIGHT, the block sends all image lines in PRIME and then continues to the padding phase.

## Timing
- `i_start` sampled at edge 0 → `o_busy` and the first `o_rd_en` (address 0) both assert in cycle 1 → `o_data_valid` asserts in cycle 3.
- With `i_data_ready` held high, the block sustains 1 beat per cycle within a burst with no bubbles.
- Credit-to-line latency: an `i_intr` rising edge at edge k with WAIT active gives the next `o_rd_en` at cycle k+2.
- `o_done` asserts in the cycle after the final handshake. `o_busy` drops in the same cycle as `o_done`.
- `axi_reset` mid-frame returns the block to reset values on the next edge. The in-flight read is discarded and the FIFO is cleared.

## Configuration
- `PIXEL_LINE_STREAMER_PAD_EN`
  - Defined: the PAD phase emits PAD_LINES zero lines, each gated by one credit.
  - Undefined: the PAD state is not compiled. WAIT goes to DRAIN after the last image line, the frame is IMG_HEIGHT*IMG_WIDTH beats, and PAD_LINES is ignored.

## Structure
- Package `pixel_line_streamer_pkg` holds:
  - the FSM state enum `pls_state_t`
  - the credit width constant `PLS_CREDIT_W = 2`
  - the FIFO depth constant `PLS_FIFO_DEPTH = 2`
- Sub-module `pls_skid_fifo` is a 2-entry synchronous FIFO with push/pop, full/empty, and count outputs. Its outputs are registered and it resets synchronously.
- The top level holds the FSM, the line, pixel, and pad counters, the edge detect, the credit counter, and the read issue logic.

## Test plan
- IMG_WIDTH=8, IMG_HEIGHT=6, PRIME_LINES=4, PAD_LINES=2, ready tied high, memory holds address mod 256. Start → 32 beats with values 0..31, then no further reads until an `i_intr` edge.
- Continuing that frame, pulse `i_intr` 4 times, 20 cycles apart → beats 32..47 (values), then 16 zeros. `o_done` pulses after beat 64 and `o_busy` drops together with it.
- Toggle `i_data_ready` pseudo-randomly (50%) → identical beat sequence; `o_data` stable while stalled; FIFO never overflows.
- Two `i_intr` edges during PRIME → credit = 2; two lines follow PRIME without further interrupts; a third edge is required for line 6.
- Assert `axi_reset` during beat 20 → all outputs 0 on the next edge. A new `i_start` restarts at address 0.
- Build with `PIXEL_LINE_STREAMER_PAD_EN` undefined → exactly 48 beats, then `o_done`; no zero beats are emitted.
